// File: rtl/div113_seq_ctrl.sv
// Sequential divide-by-constant (113): MSB-first, one radix-2^RADIX_BITS digit per cycle, quotient and remainder.
// Latency: accept edge E0, digit steps on E1..E(W/RADIX_BITS), out_valid high after the last step (8 cycles by default).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; abort drops the operation in flight.
module div113_seq_ctrl #(
  parameter int W          = 24,
  parameter int RADIX_BITS = 3,
  parameter int DIVISOR    = 113,
  parameter int RW         = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_q,
  output logic [RW-1:0] out_r,
  output logic          busy,
  input  logic          abort
);

  localparam int STEPS = W / RADIX_BITS;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TW    = RW + RADIX_BITS;
  localparam logic [KW-1:0] KLAST = KW'(STEPS - 1);
  localparam logic [TW-1:0] DIV_T = TW'(DIVISOR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // Dividend digits leave at the top while quotient digits enter at the
  // bottom, so after the last step this one register holds the quotient.
  logic [W-1:0]          xsh;
  logic [W-1:0]          xsh_next;
  logic [RW-1:0]         r;
  logic [RW-1:0]         r_next;
  logic [KW-1:0]         k;
  logic [RADIX_BITS-1:0] d;
  logic [RADIX_BITS-1:0] qd;
  logic [TW-1:0]         t;
  logic [TW-1:0]         rem;

  logic load;
  logic step;
  logic finish;

  // Digit step: t = r*2^RADIX_BITS + d, then a restoring compare/subtract
  // chain against shifted copies of the constant divisor. Because r < DIVISOR,
  // t < DIVISOR*2^RADIX_BITS, so RADIX_BITS trial subtractions give qd exactly.
  always_comb begin
    d   = xsh[W-1 -: RADIX_BITS];
    t   = {r, d};
    rem = t;
    qd  = '0;
    for (int i = RADIX_BITS - 1; i >= 0; i--) begin
      if (rem >= (DIV_T << i)) begin
        rem   = rem - (DIV_T << i);
        qd[i] = 1'b1;
      end
    end
    r_next   = rem[RW-1:0];
    xsh_next = {xsh[W-RADIX_BITS-1:0], qd};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and handshake outputs; abort beats both accept and release.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !abort) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_n = IDLE;
        end else begin
          step = 1'b1;
          if (k == KLAST) begin
            finish  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (abort || out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Working registers: load on accept, advance one digit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsh <= '0;
      r   <= '0;
      k   <= '0;
    end else if (load) begin
      xsh <= in_x;
      r   <= '0;
      k   <= '0;
    end else if (step) begin
      xsh <= xsh_next;
      r   <= r_next;
      k   <= k + 1'b1;
    end
  end

  // Result registers change only on the final step, so partial quotients
  // are never visible and the last result persists through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      out_r <= '0;
    end else if (finish) begin
      out_q <= xsh_next;
      out_r <= r_next;
    end
  end

endmodule

// File: tb/tb_div113_seq_ctrl.sv
// Bench for div113_seq_ctrl: scoreboard of floor(x/113), x mod 113 against DUT results.
// Latency: expectations pushed at accept, popped at the release handshake.
// Backpressure: directed holds, aborts, async reset, then random out_ready.
module tb_div113_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_q;
  logic [6:0]  out_r;
  logic        busy;
  logic        abort;

  typedef struct packed {
    logic [23:0] q;
    logic [6:0]  r;
  } res_t;

  res_t sb[$];
  res_t e;
  int   checks = 0;
  int   errors = 0;

  div113_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .busy      (busy),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] x);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: inputs only change just after posedge, so the negedge view
  // shows exactly what the next edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready && !abort) begin
        e.q = 24'(in_x / 24'd113);
        e.r = 7'(in_x % 24'd113);
        sb.push_back(e);
      end
      if (busy && abort) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_q", 32'(out_q), 32'(e.q));
          chk("sb_r", 32'(out_r), 32'(e.r));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] xs [3];
    logic [23:0] x;
    int m;
    bit done;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0; abort = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Latency and in_ready during RUN.
    send(24'd1000000);
    for (int i = 1; i <= 8; i++) begin
      chk("lat_valid_low", 32'(out_valid), 32'd0);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("lat_valid_high", 32'(out_valid), 32'd1);
    chk("q_1m", 32'(out_q), 32'd8849);
    chk("r_1m", 32'(out_r), 32'd63);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_valid", 32'(out_valid), 32'd0);

    // Back to back small values.
    xs[0] = 24'd0; xs[1] = 24'd112; xs[2] = 24'd113;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(xs[i]);
      wait_valid();
      tick();
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
    end

    // Maximum dividend.
    send(24'hFFFFFF);
    wait_valid();
    chk("q_max", 32'(out_q), 32'd148470);
    chk("r_max", 32'(out_r), 32'd105);
    tick();

    // Held result with a pending dividend.
    out_ready = 1'b0;
    send(24'd5000);
    wait_valid();
    in_valid = 1'b1;
    in_x     = 24'd7777;
    for (int i = 0; i < 20; i++) begin
      chk("hold_q", 32'(out_q), 32'd44);
      chk("hold_r", 32'(out_r), 32'd28);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("post_hold_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("post_hold_accept", 32'(busy), 32'd1);
    wait_valid();
    chk("q_7777", 32'(out_q), 32'd68);
    chk("r_7777", 32'(out_r), 32'd93);
    tick();

    // Abort at step 4.
    out_ready = 1'b0;
    send(24'd500000);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    send(24'd226);
    wait_valid();
    chk("q_226", 32'(out_q), 32'd2);
    chk("r_226", 32'(out_r), 32'd0);
    tick();

    // Abort and out_ready together in DONE: result dropped.
    out_ready = 1'b0;
    send(24'd300);
    wait_valid();
    out_ready = 1'b1;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("drop_in_ready", 32'(in_ready), 32'd1);
    chk("drop_sb", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-RUN.
    send(24'd123456);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_q", 32'(out_q), 32'd0);
    chk("arst_out_r", 32'(out_r), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(24'd1000);
    wait_valid();
    chk("q_1000", 32'(out_q), 32'd8);
    chk("r_1000", 32'(out_r), 32'd96);
    tick();

    // Random regression with random backpressure.
    for (int n = 0; n < 2000; n++) begin
      if (n % 50 == 0)      x = 24'hFFFFFF;
      else if (n % 7 == 0)  x = 24'($urandom_range(0, 226));
      else                  x = 24'($urandom());
      out_ready = 1'b0;
      send(x);
      m = 0;
      done = 1'b0;
      while (!done && m < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) done = 1'b1;
        tick();
        m++;
      end
      if (!done) chk("rand_timeout", 32'd0, 32'd1);
    end
    out_ready = 1'b0;

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
